// File: rtl/tdc_channel_arbiter.sv
// Round-robin arbiter sharing one fine TDC between N_CH hit channels; tags events with channel and coarse time.
// Optional calibration virtual channel enabled by defining TDC_ARB_CALIB_EN.
module tdc_channel_arbiter #(
  parameter int N_CH        = 4,
  parameter int CH_BITS     = 2,
  parameter int FINE_BITS   = 6,
  parameter int COARSE_BITS = 16,
  parameter int LATENCY     = 4,
  parameter int TIMEOUT     = 1024,
  parameter int SETTLE      = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [N_CH-1:0]        ch_req_i,
  output logic [N_CH-1:0]        ch_ack_o,
  output logic [N_CH-1:0]        tdc_sel_o,
  output logic                   tdc_arm_o,
`ifdef TDC_ARB_CALIB_EN
  input  logic                   calib_req_i,
  output logic                   tdc_cal_sel_o,
`endif
  input  logic                   hit_sync_i,
  input  logic [FINE_BITS-1:0]   value_fine_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [CH_BITS-1:0]     evt_channel_o,
  output logic [COARSE_BITS-1:0] evt_coarse_o,
  output logic [FINE_BITS-1:0]   evt_fine_o,
  output logic                   evt_timeout_o
);

`ifdef TDC_ARB_CALIB_EN
  localparam int NV = N_CH + 1;
`else
  localparam int NV = N_CH;
`endif
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int ST_W  = $clog2(SETTLE) + 1;
  localparam logic [CH_BITS:0]   NV_W     = (CH_BITS+1)'(NV);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]         LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [ST_W-1:0]    SET_LOAD = ST_W'(SETTLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CONVERT, S_HOLD, S_SETTLE} state_e;

  state_e                 state_q, state_d;
  logic [CH_BITS-1:0]     ptr_q, ptr_d, grant_q, grant_d;
  logic [COARSE_BITS-1:0] coarse_q;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [3:0]             lat_q, lat_d;
  logic [ST_W-1:0]        set_q, set_d;
  logic [CH_BITS-1:0]     chan_q, chan_d;
  logic [COARSE_BITS-1:0] ecoarse_q, ecoarse_d;
  logic [FINE_BITS-1:0]   efine_q, efine_d;
  logic                   etmo_q, etmo_d;
  logic [N_CH-1:0]        ack_q, ack_d;

  logic [NV-1:0]      req_v, req_rot;
  logic               found;
  logic [CH_BITS:0]   off, sum, nxt_sum;
  logic [CH_BITS-1:0] pick, ptr_nxt;
  logic [N_CH-1:0]    grant_oh;
  logic               armed;

`ifdef TDC_ARB_CALIB_EN
  assign req_v = {calib_req_i, ch_req_i};
`else
  assign req_v = ch_req_i;
`endif

  // Rotate so bit 0 is the pointer position; lowest set bit is the winner.
  assign req_rot = NV'({req_v, req_v} >> ptr_q);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = (CH_BITS+1)'(i);
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= NV_W) sum = sum - NV_W;
    pick = sum[CH_BITS-1:0];
  end

  always_comb begin
    nxt_sum = {1'b0, grant_q} + (CH_BITS+1)'(1);
    ptr_nxt = (nxt_sum >= NV_W) ? '0 : nxt_sum[CH_BITS-1:0];
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) grant_oh[k] = (grant_q == CH_BITS'(k));
  end

  assign armed         = (state_q == S_ARMED) || (state_q == S_CONVERT);
  assign tdc_arm_o     = armed;
  assign tdc_sel_o     = armed ? grant_oh : '0;
`ifdef TDC_ARB_CALIB_EN
  assign tdc_cal_sel_o = armed && (grant_q == CH_BITS'(N_CH));
`endif
  assign evt_valid_o   = (state_q == S_HOLD);
  assign ch_ack_o      = ack_q;
  assign evt_channel_o = chan_q;
  assign evt_coarse_o  = ecoarse_q;
  assign evt_fine_o    = efine_q;
  assign evt_timeout_o = etmo_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tmo_d     = tmo_q;
    lat_d     = lat_q;
    set_d     = set_q;
    chan_d    = chan_q;
    ecoarse_d = ecoarse_q;
    efine_d   = efine_q;
    etmo_d    = etmo_q;
    ack_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          tmo_d   = '0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (hit_sync_i) begin
          ecoarse_d = coarse_q;
          lat_d     = LAT_LOAD;
          state_d   = S_CONVERT;
        end else if (tmo_q == TMO_LAST) begin
          ecoarse_d = coarse_q;
          efine_d   = '0;
          etmo_d    = 1'b1;
          chan_d    = grant_q;
          state_d   = S_HOLD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CONVERT: begin
        if (lat_q == '0) begin
          efine_d = value_fine_i;
          etmo_d  = 1'b0;
          chan_d  = grant_q;
          state_d = S_HOLD;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (evt_ready_i) begin
          ack_d   = grant_oh;
          ptr_d   = ptr_nxt;
          set_d   = SET_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (set_q == '0) state_d = S_IDLE;
        else set_d = set_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      coarse_q  <= '0;
      tmo_q     <= '0;
      lat_q     <= '0;
      set_q     <= '0;
      chan_q    <= '0;
      ecoarse_q <= '0;
      efine_q   <= '0;
      etmo_q    <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      coarse_q  <= coarse_q + 1'b1;
      tmo_q     <= tmo_d;
      lat_q     <= lat_d;
      set_q     <= set_d;
      chan_q    <= chan_d;
      ecoarse_q <= ecoarse_d;
      efine_q   <= efine_d;
      etmo_q    <= etmo_d;
      ack_q     <= ack_d;
    end
  end

endmodule

// File: tb/tb_tdc_channel_arbiter.sv
// Directed bench for tdc_channel_arbiter: event-level reference model plus hand-computed literal checks.
module tb_tdc_channel_arbiter;
  localparam int N_CH = 4, CH_BITS = 2, FINE_BITS = 6, COARSE_BITS = 16;
  localparam int LATENCY = 4, TIMEOUT = 1024, SETTLE = 3;
  localparam int P_IDLE = 0, P_ARM = 1, P_CONV = 2, P_HOLD = 3, P_SET = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N_CH-1:0] ch_req, ch_ack, tdc_sel;
  logic tdc_arm, hit, evt_valid, ready, evt_timeout;
  logic [FINE_BITS-1:0] fine, evt_fine;
  logic [CH_BITS-1:0] evt_channel;
  logic [COARSE_BITS-1:0] evt_coarse;

  always #5 clk = ~clk;

  tdc_channel_arbiter #(.N_CH(N_CH), .CH_BITS(CH_BITS), .FINE_BITS(FINE_BITS),
    .COARSE_BITS(COARSE_BITS), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clock_i(clk), .reset_i(rst), .ch_req_i(ch_req), .ch_ack_o(ch_ack),
    .tdc_sel_o(tdc_sel), .tdc_arm_o(tdc_arm), .hit_sync_i(hit), .value_fine_i(fine),
    .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_channel_o(evt_channel),
    .evt_coarse_o(evt_coarse), .evt_fine_o(evt_fine), .evt_timeout_o(evt_timeout));

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: absolute cycle deadlines derived from the event rules.
  int m_n = 0, m_ph = P_IDLE, m_ptr = 0, m_grant = 0, m_coarse = 0;
  int m_since = 0, m_fire = 0, m_idle = 0;
  int e_ack = 0, e_chan = 0, e_coarse = 0, e_fine = 0, e_tmo = 0;

  always @(posedge clk) begin
    int rq, c;
    m_n++;
    e_ack = 0;
    if (!rst) begin
      m_ph = P_IDLE; m_ptr = 0; m_grant = 0; m_coarse = 0;
      e_chan = 0; e_coarse = 0; e_fine = 0; e_tmo = 0;
    end else begin
      rq = int'(ch_req);
      case (m_ph)
        P_IDLE: for (int k = N_CH - 1; k >= 0; k--) begin
          c = (m_ptr + k) % N_CH;
          if (((rq >> c) & 1) == 1) begin m_grant = c; m_ph = P_ARM; m_since = m_n; end
        end
        P_ARM: if (hit) begin
          e_coarse = m_coarse; m_fire = m_n + LATENCY; m_ph = P_CONV;
        end else if (m_n - m_since == TIMEOUT) begin
          e_coarse = m_coarse; e_fine = 0; e_tmo = 1; e_chan = m_grant; m_ph = P_HOLD;
        end
        P_CONV: if (m_n == m_fire) begin
          e_fine = int'(fine); e_tmo = 0; e_chan = m_grant; m_ph = P_HOLD;
        end
        P_HOLD: if (ready) begin
          e_ack = 1 << m_grant; m_ptr = (m_grant + 1) % N_CH; m_idle = m_n + SETTLE; m_ph = P_SET;
        end
        P_SET: if (m_n == m_idle) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
      m_coarse = (m_coarse + 1) % (1 << COARSE_BITS);
    end
  end

  always @(negedge clk) begin
    bit ea;
    if (chk_en) begin
      ea = (m_ph == P_ARM) || (m_ph == P_CONV);
      chk("tdc_arm", int'(tdc_arm), int'(ea));
      chk("tdc_sel", int'(tdc_sel), ea ? (1 << m_grant) : 0);
      chk("ch_ack", int'(ch_ack), e_ack);
      chk("evt_valid", int'(evt_valid), int'(m_ph == P_HOLD));
      if (m_ph == P_HOLD) begin
        chk("evt_channel", int'(evt_channel), e_chan);
        chk("evt_coarse", int'(evt_coarse), e_coarse);
        chk("evt_fine", int'(evt_fine), e_fine);
        chk("evt_timeout", int'(evt_timeout), e_tmo);
      end
    end
  end

  task automatic wait_arm(input string nm);
    for (int i = 0; i < 40 && !tdc_arm; i++) @(negedge clk);
    chk(nm, int'(tdc_arm), 1);
  endtask

  task automatic hit_and_wait(input logic [FINE_BITS-1:0] f, output int lat);
    hit = 1'b1; fine = f; lat = 0;
    do begin @(negedge clk); hit = 1'b0; lat++; end while (!evt_valid && lat < 20);
  endtask

  initial begin
    int lat, n, acks, lows, cap_c;
    int seq[5] = '{0, 1, 2, 3, 0};
    rst = 1'b0; ch_req = '0; hit = 1'b0; fine = '0; ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_arm", int'(tdc_arm), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ack", int'(ch_ack), 0);
    chk("rst_chan", int'(evt_channel), 0);

    // single channel 2 request out of reset
    rst = 1'b1; ch_req = 4'b0100;
    @(negedge clk);
    chk("t1_sel", int'(tdc_sel), 4);
    chk("t1_arm", int'(tdc_arm), 1);
    ch_req = '0;

    // hit at coarse 0x0010, fine 37
    for (int i = 0; i < 40 && m_coarse != 16; i++) @(negedge clk);
    hit_and_wait(6'd37, lat);
    chk("t2_latency", lat, LATENCY + 1);
    chk("t2_chan", int'(evt_channel), 2);
    chk("t2_coarse", int'(evt_coarse), 16);
    chk("t2_fine", int'(evt_fine), 37);
    chk("t2_tmo", int'(evt_timeout), 0);
    @(negedge clk);
    chk("t2_ack", int'(ch_ack), 4);
    @(negedge clk);
    chk("t2_ack_end", int'(ch_ack), 0);

    // reset during CONVERT: pointer was 3, ch1 wins
    ch_req = 4'b0010;
    wait_arm("t6_arm");
    chk("t6_sel", int'(tdc_sel), 2);
    hit = 1'b1; fine = 6'd5;
    @(negedge clk); hit = 1'b0;
    @(negedge clk); rst = 1'b0; ch_req = '0;
    @(negedge clk);
    chk("t6_arm0", int'(tdc_arm), 0);
    chk("t6_sel0", int'(tdc_sel), 0);
    chk("t6_valid0", int'(evt_valid), 0);
    chk("t6_coarse0", int'(evt_coarse), 0);
    chk("t6_fine0", int'(evt_fine), 0);
    @(negedge clk);
    chk("t6_noack", int'(ch_ack), 0);
    rst = 1'b1; ch_req = 4'b1111;

    // fairness with all channels requesting
    for (int e = 0; e < 5; e++) begin
      wait_arm("t3_arm");
      hit_and_wait(6'(e + 20), lat);
      chk("t3_valid", int'(evt_valid), 1);
      chk("t3_chan", int'(evt_channel), seq[e]);
    end
    ch_req = 4'b0010;

    // timeout on ch1; request withdrawn while armed
    wait_arm("t4_arm");
    chk("t4_sel", int'(tdc_sel), 2);
    ch_req = '0; n = 0;
    do begin @(negedge clk); n++; end while (!evt_valid && n < 1100);
    chk("t4_wait", n, TIMEOUT);
    chk("t4_tmo", int'(evt_timeout), 1);
    chk("t4_fine", int'(evt_fine), 0);
    chk("t4_chan", int'(evt_channel), 1);
    chk("t4_arm", int'(tdc_arm), 0);
    @(negedge clk); hit = 1'b1;
    @(negedge clk); hit = 1'b0;

    // back-pressure in HOLD, then settle gap before re-arm
    ch_req = 4'b0001; ready = 1'b0;
    wait_arm("t5_arm");
    hit_and_wait(6'd63, lat);
    cap_c = int'(evt_coarse);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_valid", int'(evt_valid), 1);
      chk("t5_fine", int'(evt_fine), 63);
      chk("t5_chan", int'(evt_channel), 0);
      chk("t5_coarse", int'(evt_coarse), cap_c);
      chk("t5_noack", int'(ch_ack), 0);
    end
    ready = 1'b1; acks = 0; lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ch_ack != '0) acks++;
      if (tdc_arm) break;
      lows++;
    end
    chk("t5_ack_count", acks, 1);
    chk("t5_arm_low", lows, SETTLE + 1);
    ch_req = '0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
